ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
- Input-side counterpart to the free-running counter/seven-segment display path: receives serial PS/2 keyboard frames and delivers scan-code bytes into the system clock domain.
- Oversamples the external ps2_clk/ps2_data lines with sys_clk and assembles 11-bit frames.
- Checks framing and parity, then buffers good bytes in a small show-ahead FIFO for the consumer, e.g. display or key-decode logic.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; must be a power of two.
- FIFO_AW, 3, log2(FIFO_DEPTH).
- TIMEOUT, 50000, sys_clk cycles with no ps2_clk falling edge before a partial frame is discarded.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  PS/2 clock from device, asynchronous.
- ps2_data  input  1  PS/2 data from device, asynchronous.
- rd_en  input  1  consumer pops the head byte when high for one cycle.
- data  output  8  head-of-FIFO byte, show-ahead.
- valid  output  1  FIFO non-empty; data is meaningful.
- overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad start, stop or parity bit.

Behaviour:
- Reset is asynchronous; all state clears immediately:
  - bit count = 0, FIFO pointers = 0.
  - valid = 0, data = 8'h00, overflow = 0, frame_err = 0.
  - synchronizer flops = 1 (line idle high).
- Synchronization and edge detect:
  - ps2_clk passes through a 3-flop synchronizer.
  - A falling edge is detected when the last two stages are 1 then 0.
  - ps2_data passes through a 2-flop synchronizer and is sampled on the detected edge.
- Frame assembly:
  - 11 bits per frame, LSB first: start(0), d0..d7, parity, stop(1).
  - A 4-bit counter runs 0..10. Bits 0..9 are stored in a shift buffer; the counter increments on each edge.
  - On the edge with count = 10, the stop bit is sampled and the frame is evaluated; the counter returns to 0 that cycle.
- Frame check, all three required:
  - start == 0.
  - stop == 1.
  - XOR of d0..d7 and the parity bit == 1 (odd parity).
- Good frame:
  - If the FIFO is not full, the byte is written.
  - If the FIFO is full, the byte is dropped and overflow is set. overflow stays set until reset.
- Bad frame: byte dropped; frame_err is high for exactly the next cycle; FIFO unchanged.
- Latency: valid rises and data shows the byte on the cycle after the stop-bit edge is detected. That is about 4 sys_clk cycles after the stop-bit ps2_clk fall at the pin.
- Timeout:
  - An idle counter increments while count != 0 and resets on every edge.
  - When it reaches TIMEOUT, count returns to 0 and the partial frame is discarded silently (no frame_err).
- FIFO:
  - Write and read pointers are FIFO_AW+1 bits.
  - empty when the pointers are equal; full when the MSBs differ and the rest are equal.
  - data = mem[rd_ptr[FIFO_AW-1:0]], combinational from registered pointers. data holds its last value when empty.
  - rd_en while valid=1: rd_ptr increments; the next byte is visible the following cycle.
  - rd_en while empty: ignored, no pointer change.
- Simultaneous read and write:
  - A read and a write in the same cycle both take effect; count is unchanged.
  - If full with a simultaneous rd_en, the incoming write is accepted and overflow does not set.
- Reset mid-frame: the partial frame is lost; the first full frame after reset release is received normally.

Test Plan:
- Send 0x1C (parity bit 0, stop 1) at a 10 kHz PS/2 clock, no reads -> valid=1 within 5 cycles of the stop edge, data=8'h1C, frame_err never pulses; pulse rd_en -> valid=0 next cycle.
- Send 0x1C with parity bit 1 -> frame_err high for exactly 1 cycle, valid stays 0; then send 0xF0 (parity 1) -> data=8'hF0, valid=1.
- Send bytes 0x01..0x09 with correct parity, no reads -> overflow=1 after the 9th frame; eight rd_en pulses return 0x01..0x08 in order, then valid=0.
- Send 5 bits of a frame, hold idle for TIMEOUT+10 cycles, then a full 0x5A frame -> data=8'h5A, valid=1, frame_err never pulses.
- With the FIFO full, assert rd_en on the cycle of the 9th byte's write -> overflow stays 0, FIFO still holds 8 entries, the last entry equals the 9th byte.
- Assert sys_rst_n=0 after 6 bits of a frame, release, then send 0x29 -> valid=1, data=8'h29; pulse rd_en with the FIFO empty -> no change.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_data, assembles 11-bit frames,
// checks framing/odd parity and queues good scan-code bytes in a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam int unsigned PW = FIFO_AW + 1;

    logic [2:0]    ps2c_q;
    logic [1:0]    ps2d_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [PW-1:0] wp_q, rp_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          overflow_q, ferr_q;

    logic fall, sbit, frame_done, frame_good;
    logic empty, full, wr_req, rd_do, wr_do;

    // Oldest two clock stages going 1 -> 0 marks a falling edge.
    assign fall = ps2c_q[2] & ~ps2c_q[1];
    assign sbit = ps2d_q[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ps2c_q <= 3'b111;
            ps2d_q <= 2'b11;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[0], ps2_data};
        end
    end

    // Bit counter, shift buffer and partial-frame timeout.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        idle_d     = idle_q;
        frame_done = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (cnt_q == 4'd10) begin
                cnt_d      = 4'd0;
                frame_done = 1'b1;
            end else begin
                shift_d[cnt_q] = sbit;
                cnt_d          = cnt_q + 4'd1;
            end
        end else if (cnt_q != 4'd0) begin
            if (idle_q == IW'(TIMEOUT)) begin
                cnt_d  = 4'd0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q   <= 4'd0;
            shift_q <= 10'd0;
            idle_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
        end
    end

    // shift_q holds start at [0], d0..d7 at [8:1], parity at [9].
    assign frame_good = ~shift_q[0] & sbit & (^shift_q[9:1]);

    assign empty  = (wp_q == rp_q);
    assign full   = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                    (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
    assign wr_req = frame_done & frame_good;
    assign rd_do  = rd_en & ~empty;
    // A pop in the same cycle frees the slot the incoming byte lands in.
    assign wr_do  = wr_req & (~full | rd_do);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            overflow_q <= 1'b0;
            ferr_q     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (wr_do) begin
                mem_q[wp_q[FIFO_AW-1:0]] <= shift_q[8:1];
                wp_q                     <= wp_q + PW'(1);
            end
            if (rd_do) begin
                rp_q <= rp_q + PW'(1);
            end
            overflow_q <= overflow_q | (wr_req & full & ~rd_do);
            ferr_q     <= frame_done & ~frame_good;
        end
    end

    assign data      = mem_q[rp_q[FIFO_AW-1:0]];
    assign valid     = ~empty;
    assign overflow  = overflow_q;
    assign frame_err = ferr_q;

endmodule
